// File: rtl/wb_req_master_if.sv
// Core request/response port and Wishbone classic master bus of wb_req_master.
// The master modport is the wb_req_master side; slave is the core plus memory.
interface wb_req_master_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_data_i;
  logic [7:0]  req_sel_i;
  logic        rsp_valid_o;
  logic        rsp_we_o;
  logic [63:0] rsp_data_o;
  logic        rsp_err_o;
  logic        wbm_cycle_o;
  logic        wbm_strobe_o;
  logic        wbm_we_o;
  logic [63:0] wbm_addr_o;
  logic [63:0] wbm_data_o;
  logic [7:0]  wbm_sel_o;
  logic [63:0] wbm_data_i;
  logic        wbm_ack_i;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i,
    input  req_data_i, req_sel_i,
    input  wbm_data_i, wbm_ack_i,
    output req_ready_o,
    output rsp_valid_o, rsp_we_o, rsp_data_o, rsp_err_o,
    output wbm_cycle_o, wbm_strobe_o, wbm_we_o,
    output wbm_addr_o, wbm_data_o, wbm_sel_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i,
    output req_data_i, req_sel_i,
    output wbm_data_i, wbm_ack_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_we_o, rsp_data_o, rsp_err_o,
    input  wbm_cycle_o, wbm_strobe_o, wbm_we_o,
    input  wbm_addr_o, wbm_data_o, wbm_sel_o
  );
endinterface

// File: rtl/wb_req_master.sv
// Queued Wishbone classic single-cycle master with ack watchdog.
// Define WB_REQ_MASTER_STATS_EN to add saturating rd/wr/err counters.
module wb_req_master #(
  parameter int QUEUE_AW       = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              sys_clock_i,
  input logic              sys_reset_i,
  wb_req_master_if.master  bus
`ifdef WB_REQ_MASTER_STATS_EN
  ,
  output logic [31:0]      stat_rd_o,
  output logic [31:0]      stat_wr_o,
  output logic [31:0]      stat_err_o
`endif
);

  localparam int DEPTH = 1 << QUEUE_AW;
  localparam logic [QUEUE_AW:0] CNT_FULL = (QUEUE_AW+1)'(DEPTH);
  localparam logic [QUEUE_AW:0] CNT_ONE  = (QUEUE_AW+1)'(1);
  localparam logic [QUEUE_AW-1:0] PTR_ONE = QUEUE_AW'(1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  sel;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  req_t                q_mem [DEPTH];
  logic [QUEUE_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [QUEUE_AW:0]   count_q;
  logic                full, push, pop;
  req_t                head, in_req;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdat_q, wdat_d;
  logic [7:0]  sel_q, sel_d;
  logic        rv_q, rv_d;
  logic        rwe_q, rwe_d;
  logic [63:0] rdat_q, rdat_d;
  logic        rerr_q, rerr_d;

  // Ready comes from the registered count only, so a full queue
  // never accepts a push even while it is being popped.
  assign full   = (count_q == CNT_FULL);
  assign push   = bus.req_valid_i & ~full;
  assign head   = q_mem[rd_ptr_q];
  assign in_req = '{we:   bus.req_we_i,
                    addr: bus.req_addr_i,
                    data: bus.req_data_i,
                    sel:  bus.req_sel_i};

  always_ff @(posedge sys_clock_i) begin
    if (push) q_mem[wr_ptr_q] <= in_req;
  end

  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    rv_d    = rv_q;
    rwe_d   = rwe_q;
    rdat_d  = rdat_q;
    rerr_d  = rerr_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cyc_d   = 1'b1;
          we_d    = head.we;
          addr_d  = head.addr;
          wdat_d  = head.we ? head.data : '0;
          sel_d   = head.sel;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack has priority over a watchdog expiry in the same cycle.
        if (bus.wbm_ack_i) begin
          cyc_d   = 1'b0;
          rv_d    = 1'b1;
          rwe_d   = we_q;
          rdat_d  = we_q ? '0 : bus.wbm_data_i;
          rerr_d  = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          cyc_d   = 1'b0;
          rv_d    = 1'b1;
          rwe_d   = we_q;
          rdat_d  = '0;
          rerr_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        rv_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      rv_q    <= 1'b0;
      rwe_q   <= 1'b0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      rv_q    <= rv_d;
      rwe_q   <= rwe_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
    end
  end

  assign bus.req_ready_o  = ~full;
  assign bus.rsp_valid_o  = rv_q;
  assign bus.rsp_we_o     = rwe_q;
  assign bus.rsp_data_o   = rdat_q;
  assign bus.rsp_err_o    = rerr_q;
  assign bus.wbm_cycle_o  = cyc_q;
  assign bus.wbm_strobe_o = cyc_q;
  assign bus.wbm_we_o     = we_q;
  assign bus.wbm_addr_o   = addr_q;
  assign bus.wbm_data_o   = wdat_q;
  assign bus.wbm_sel_o    = sel_q;

`ifdef WB_REQ_MASTER_STATS_EN
  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_i) begin
      stat_rd_o  <= '0;
      stat_wr_o  <= '0;
      stat_err_o <= '0;
    end else if (rv_q) begin
      if (rerr_q) begin
        if (stat_err_o != '1) stat_err_o <= stat_err_o + 32'd1;
      end else if (rwe_q) begin
        if (stat_wr_o != '1) stat_wr_o <= stat_wr_o + 32'd1;
      end else begin
        if (stat_rd_o != '1) stat_rd_o <= stat_rd_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_req_master.sv
// Scoreboard bench for wb_req_master against a registered-ack memory.
// Stats checks run only when WB_REQ_MASTER_STATS_EN is defined.
module tb_wb_req_master;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_req_master_if bus();

`ifdef WB_REQ_MASTER_STATS_EN
  logic [31:0] stat_rd, stat_wr, stat_err;
`endif

  wb_req_master #(
    .QUEUE_AW(2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clock_i(clk),
    .sys_reset_i(rst_n),
    .bus(bus)
`ifdef WB_REQ_MASTER_STATS_EN
    ,
    .stat_rd_o(stat_rd),
    .stat_wr_o(stat_wr),
    .stat_err_o(stat_err)
`endif
  );

  typedef struct packed {
    logic        we;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mem [16];
  logic [63:0] ref_mem [16];
  logic        stall = 1'b0;
  logic        noack = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          cyc_n = 0;
  int          acc_cyc = 0;
  int          last_cyc = 0;
  int          t_rise = 0;
  int          t_fall = -1;
  logic        cyc_prev = 1'b0;
  logic [63:0] last_data = '0;
  logic        last_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old,
                                        input logic [63:0] d,
                                        input logic [7:0] sel);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++)
      if (sel[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Registered-ack memory slave
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.wbm_ack_i  <= 1'b0;
      bus.wbm_data_i <= '0;
    end else if (bus.wbm_cycle_o && bus.wbm_strobe_o && !bus.wbm_ack_i
                 && !stall && !noack) begin
      bus.wbm_ack_i <= 1'b1;
      if (bus.wbm_we_o)
        mem[bus.wbm_addr_o[6:3]] <= merge(mem[bus.wbm_addr_o[6:3]],
                                          bus.wbm_data_o, bus.wbm_sel_o);
      else
        bus.wbm_data_i <= mem[bus.wbm_addr_o[6:3]];
    end else begin
      bus.wbm_ack_i <= 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!cyc_prev && bus.wbm_cycle_o) t_rise = cyc_n;
    if (cyc_prev && !bus.wbm_cycle_o) t_fall = cyc_n;
    cyc_prev = bus.wbm_cycle_o;
    if (rst_n && bus.rsp_valid_o) begin
      last_cyc  = cyc_n;
      last_data = bus.rsp_data_o;
      last_err  = bus.rsp_err_o;
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_we", {63'd0, bus.rsp_we_o}, {63'd0, e.we});
        check("rsp_data", bus.rsp_data_o, e.data);
        check("rsp_err", {63'd0, bus.rsp_err_o}, {63'd0, e.err});
      end
    end
  end

  task automatic send(input logic we, input logic [63:0] addr,
                      input logic [63:0] data, input logic [7:0] sel,
                      input logic err);
    exp_t e;
    int i;
    i = 0;
    while (!bus.req_ready_o && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (!bus.req_ready_o) check("ready_wait", 64'd0, 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_data_i  = data;
    bus.req_sel_i   = sel;
    e.we   = we;
    e.err  = err;
    e.data = (we || err) ? 64'd0 : ref_mem[addr[6:3]];
    if (we && !err)
      ref_mem[addr[6:3]] = merge(ref_mem[addr[6:3]], data, sel);
    sb.push_back(e);
    @(posedge clk);
    #1 acc_cyc = cyc_n;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    int t0;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.req_sel_i   = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, bus.req_ready_o}, 64'd1);
    check("rst_cycle", {63'd0, bus.wbm_cycle_o}, 64'd0);
    check("rst_rsp", {63'd0, bus.rsp_valid_o}, 64'd0);
    check("rst_addr", bus.wbm_addr_o, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write then read back with latency check
    send(1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 1'b0);
    drain();
    check("wr_addr", bus.wbm_addr_o, 64'h10);
    check("wr_we", {63'd0, bus.wbm_we_o}, 64'd1);
    send(1'b0, 64'h10, 64'h0, 8'hFF, 1'b0);
    t0 = acc_cyc;
    drain();
    check("rd_addr", bus.wbm_addr_o, 64'h10);
    check("rd_data", last_data, 64'h1122334455667788);
    check("rd_err", {63'd0, last_err}, 64'd0);
    check("rd_latency", 64'(last_cyc - t0), 64'd3);

    // Partial byte-select write
    send(1'b1, 64'h20, 64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b0);
    send(1'b0, 64'h20, 64'h0, 8'hFF, 1'b0);
    drain();
    check("sel_data", last_data, 64'h00000000BBBBBBBB);

    // Five back-to-back requests against a stalled slave
    stall = 1'b1;
    send(1'b1, 64'h30, 64'hDEAD0001, 8'hFF, 1'b0);
    send(1'b1, 64'h38, 64'hDEAD0002, 8'hFF, 1'b0);
    send(1'b0, 64'h30, 64'h0, 8'hFF, 1'b0);
    send(1'b0, 64'h38, 64'h0, 8'hFF, 1'b0);
    check("ready_before_full", {63'd0, bus.req_ready_o}, 64'd1);
    send(1'b1, 64'h48, 64'hDEAD0005, 8'h03, 1'b0);
    check("ready_full", {63'd0, bus.req_ready_o}, 64'd0);
    stall = 1'b0;
    drain();
    check("ready_after", {63'd0, bus.req_ready_o}, 64'd1);

    // Slave ignores strobe until the watchdog fires
    noack = 1'b1;
    t_fall = -1;
    send(1'b0, 64'h40, 64'h0, 8'hFF, 1'b1);
    send(1'b0, 64'h10, 64'h0, 8'hFF, 1'b0);
    for (int i = 0; i < 100 && t_fall < 0; i++) @(negedge clk);
    noack = 1'b0;
    check("timeout_cycles", 64'(t_fall - t_rise), 64'(TO));
    drain();
    check("post_to_data", last_data, 64'h1122334455667788);

    // Reset while a cycle is open and two requests are queued
    stall = 1'b1;
    send(1'b0, 64'h10, 64'h0, 8'hFF, 1'b0);
    send(1'b0, 64'h20, 64'h0, 8'hFF, 1'b0);
    send(1'b0, 64'h30, 64'h0, 8'hFF, 1'b0);
    check("pre_rst_cycle", {63'd0, bus.wbm_cycle_o}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_cycle", {63'd0, bus.wbm_cycle_o}, 64'd0);
    check("mid_rst_strobe", {63'd0, bus.wbm_strobe_o}, 64'd0);
    check("mid_rst_ready", {63'd0, bus.req_ready_o}, 64'd1);
    check("mid_rst_rsp", {63'd0, bus.rsp_valid_o}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (10) @(negedge clk);
    send(1'b0, 64'h38, 64'h0, 8'hFF, 1'b0);
    drain();
    check("post_rst_data", last_data, 64'hDEAD0002);

`ifdef WB_REQ_MASTER_STATS_EN
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("stat_rd_rst", {32'd0, stat_rd}, 64'd0);
    send(1'b0, 64'h10, 64'h0, 8'hFF, 1'b0);
    send(1'b1, 64'h50, 64'h5555, 8'hFF, 1'b0);
    send(1'b0, 64'h50, 64'h0, 8'hFF, 1'b0);
    send(1'b1, 64'h58, 64'h6666, 8'hFF, 1'b0);
    send(1'b0, 64'h58, 64'h0, 8'hFF, 1'b0);
    drain();
    noack = 1'b1;
    send(1'b0, 64'h60, 64'h0, 8'hFF, 1'b1);
    drain();
    noack = 1'b0;
    repeat (2) @(negedge clk);
    check("stat_rd", {32'd0, stat_rd}, 64'd3);
    check("stat_wr", {32'd0, stat_wr}, 64'd2);
    check("stat_err", {32'd0, stat_err}, 64'd1);
`endif

    repeat (4) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_req_master.md
Name: wb_req_master

Overview:
- Wishbone master front-end that sits directly upstream of the testbench memory harness (Wishbone slave).
- Accepts single read/write requests from a core-side valid/ready port and buffers them in a small in-order queue.
- Issues one Wishbone classic single cycle per request.
- Returns read data or write completion on a one-cycle response pulse, with a watchdog timeout for a slave that never acks.

Parameters:
QUEUE_AW, 2, log2 of request queue depth (depth = 4)
TIMEOUT_CYCLES, 255, max cycles in BUS state without ack before error (1..255)

Ports:
sys_clock_i  in  1  system clock
sys_reset_i  in  1  synchronous reset, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  queue not full
req_we_i  in  1  1=write, 0=read
req_addr_i  in  64  byte address
req_data_i  in  64  write data
req_sel_i  in  8  byte selects
rsp_valid_o  out  1  one-cycle response pulse
rsp_we_o  out  1  response belongs to a write
rsp_data_o  out  64  read data; 0 for writes and errors
rsp_err_o  out  1  timeout occurred
wbm_cycle_o  out  1  Wishbone cycle
wbm_strobe_o  out  1  Wishbone strobe
wbm_we_o  out  1  Wishbone write enable
wbm_addr_o  out  64  Wishbone address
wbm_data_o  out  64  Wishbone write data
wbm_sel_o  out  8  Wishbone byte select
wbm_data_i  in  64  Wishbone read data
wbm_ack_i  in  1  Wishbone ack

Behaviour:
- All state and outputs are registered. On sys_reset_i=0 at an edge:
  - All outputs go to 0, except req_ready_o=1.
  - Queue is flushed and FSM goes to IDLE.
- Reset mid-transaction abandons the cycle: cycle/strobe drop at that edge and no response is produced.
- Queue:
  - Push when req_valid_i & req_ready_o. A push stores {we, addr, data, sel}.
  - req_ready_o = !full, derived from the registered count. A pop in the same cycle does not admit a push when full (no bypass).
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo depth.
- FSM, states IDLE, BUS, RESP:
  - IDLE: if the queue is non-empty at the edge, pop the head into the wbm_* registers, set cycle=strobe=1, go to BUS. For reads, wbm_data_o=0.
  - BUS: timeout counter increments every cycle.
    - On wbm_ack_i=1: clear cycle/strobe, latch wbm_data_i (reads only), go to RESP with rsp_valid_o=1, rsp_err_o=0.
    - Else, if counter == TIMEOUT_CYCLES-1: clear cycle/strobe, go to RESP with rsp_err_o=1, rsp_data_o=0.
    - Ack wins if it coincides with timeout.
  - RESP: rsp_valid_o cleared at the next edge, go to IDLE. rsp_valid_o therefore lasts exactly one cycle, with no backpressure.
- wbm_ack_i is ignored outside BUS. This absorbs the extra ack cycle that a registered-ack slave produces after strobe drops.
- wbm_addr_o, wbm_we_o and wbm_sel_o hold their last values while idle.
- Latency, with an empty queue and a slave that acks one edge after sampling strobe:
  - Request accepted at edge A.
  - cycle/strobe high after edge A+1.
  - rsp_valid_o high after edge A+3.
- Throughput: one transaction per 4 cycles.
- Responses are returned strictly in request order.

Optional Feature:
WB_REQ_MASTER_STATS_EN:
- Defined: adds ports stat_rd_o, stat_wr_o and stat_err_o, each out, 32 bits, saturating at 0xFFFFFFFF. On each rsp_valid_o:
  - rsp_err_o=1 increments stat_err_o.
  - Otherwise the read or write counter increments according to rsp_we_o.
  - All three reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
1. Write addr 0x10, data 0x1122334455667788, sel 0xFF, then read 0x10 against the memory harness:
   - wbm_addr_o=0x10 on both cycles.
   - Read rsp_data_o=0x1122334455667788, rsp_err_o=0.
   - rsp_valid_o asserts 3 cycles after the read is accepted.
2. Write sel 0x0F, data 0xAAAAAAAABBBBBBBB to a location preloaded with 0 -> subsequent read returns 0x00000000BBBBBBBB.
3. Push 5 back-to-back requests with the slave stalled:
   - req_ready_o drops after 4 are queued.
   - All 5 responses arrive in order.
   - No request is lost or duplicated.
4. Slave never acks, TIMEOUT_CYCLES=8:
   - cycle/strobe drop after 8 cycles in BUS.
   - rsp_valid_o=1 with rsp_err_o=1, rsp_data_o=0.
   - The next queued request proceeds normally.
5. Assert sys_reset_i=0 while in BUS with 2 requests queued:
   - Next edge: cycle/strobe=0, req_ready_o=1, no response.
   - A post-reset read completes normally.
6. With WB_REQ_MASTER_STATS_EN defined, run 3 reads, 2 writes and 1 timeout -> stat_rd_o=3, stat_wr_o=2, stat_err_o=1.
